rwm_frame_ctrl: RTL and testbench
=================================

RWM_FRAME_CTRL -- requirements
Module: rwm_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000: max cycles to wait for RWM_done per operation.
REQ-002 Parameter CLEAR_EN, default 1: 1 = clear the RWM before every capture; 0 = skip the clear.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  active-high request to run one frame sequence.
REQ-006 abort  input  1  active-high; cancels any sequence and returns to IDLE.
REQ-007 cam_frame_valid  input  1  camera has a frame ready to stream.
REQ-008 RWM_done  input  1  completion pulse from the RWM.
REQ-009 RWM_enable  output  1  one-cycle command strobe to the RWM.
REQ-010 rw  output  1  1 = write, 0 = read; stable for the whole operation.
REQ-011 clear  output  1  clear command; stable for the whole clear operation.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse when a full sequence completes.
REQ-014 error  output  1  sticky timeout flag.
REQ-015 frame_cnt  output  8  count of completed frames; wraps from 255 to 0.

Function
REQ-016 States: IDLE, CLR_CMD, CLR_WAIT, CAP_ARM, CAP_CMD, CAP_WAIT, RD_CMD, RD_WAIT, DONE, ERR. All outputs are registered.
REQ-017 IDLE + start=1: next state is CLR_CMD if CLEAR_EN=1, otherwise CAP_ARM. start is ignored in every other state.
REQ-018 CLR_CMD lasts 1 cycle: RWM_enable=1, clear=1. Then CLR_WAIT.
REQ-019 CLR_WAIT: clear held at 1 and RWM_enable=0. On RWM_done=1, clear drops to 0 and the next state is CAP_ARM.
REQ-020 CAP_ARM: wait indefinitely, with no timeout, for cam_frame_valid=1, then go to CAP_CMD.
REQ-021 CAP_CMD lasts 1 cycle: RWM_enable=1, rw=1. Then CAP_WAIT with rw held at 1 until RWM_done, then RD_CMD.
REQ-022 RD_CMD lasts 1 cycle: RWM_enable=1, rw=0. Then RD_WAIT until RWM_done, then DONE.
REQ-023 DONE lasts 1 cycle: frame_done=1, frame_cnt increments by 1 modulo 256, then IDLE.
REQ-024 RWM_enable is never high for 2 consecutive cycles.
REQ-025 RWM_enable is never high outside the CLR_CMD, CAP_CMD and RD_CMD states.
REQ-026 Command-to-done latency is unbounded but limited by timeout; RWM_done arriving in any non-WAIT state is ignored.
REQ-027 Timeout counter: 16 bits, cleared on entry to every WAIT state, increments each cycle in WAIT while RWM_done=0.
REQ-028 Timeout trigger: when the counter reaches TIMEOUT-1 without RWM_done, the next state is ERR and error is set to 1.
REQ-029 RWM_done in the same cycle the counter reaches TIMEOUT-1: treat it as success, with no error.
REQ-030 ERR: rw=0, clear=0, RWM_enable=0, busy=1. Leave ERR only on abort.
REQ-031 abort=1 in any state: the next state is IDLE.
REQ-032 abort forces rw=0, clear=0, RWM_enable=0 and error=0; frame_cnt is unchanged.
REQ-033 abort has priority over start, RWM_done, cam_frame_valid and the timeout.
REQ-034 abort together with start in IDLE: stay in IDLE.
REQ-035 rw is 0 in every state except CAP_CMD and CAP_WAIT; clear is 0 in every state except CLR_CMD and CLR_WAIT.

Reset
REQ-036 rst_n=0 immediately forces state=IDLE and clears the timeout counter.
REQ-037 rst_n=0 forces RWM_enable=0, rw=0, clear=0, busy=0, frame_done=0, error=0 and frame_cnt=0, independent of clk.
REQ-038 Reset asserted mid-operation abandons the sequence; no frame_done is produced and the sequence does not resume after reset deasserts.

Verification
REQ-039 Nominal, CLEAR_EN=1: start pulse; cam_frame_valid=1; RWM model returns done 10 cycles after each strobe -> strobes in order clear, write, read. Then one frame_done pulse, frame_cnt=1, busy=0.
REQ-040 CLEAR_EN=0: start -> the first strobe has rw=1 and clear=0, with no clear strobe in the sequence.
REQ-041 Timeout, TIMEOUT=100: RWM_done never arrives after the write strobe -> error=1 exactly 100 cycles after entering CAP_WAIT. Then state stays ERR; abort -> error=0, IDLE.
REQ-042 Abort in the same cycle as RWM_done in RD_WAIT -> IDLE, no frame_done, frame_cnt unchanged.
REQ-043 Run 256 frames back-to-back -> frame_cnt wraps to 0. Check every frame: RWM_enable is never high 2 cycles in a row, and start pulses while busy are ignored.
REQ-044 Assert rst_n=0 during CAP_WAIT -> all outputs 0 asynchronously. After release, a new start runs a full sequence normally.

Source files
------------

// File: rtl/rwm_frame_ctrl.sv
// rwm_frame_ctrl: sequences clear, capture-write and readback commands
// to the RWM for one camera frame, with a per-operation timeout.
module rwm_frame_ctrl #(
  parameter logic [15:0] TIMEOUT  = 16'd50000,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cam_frame_valid,
  input  logic       RWM_done,
  output logic       RWM_enable,
  output logic       rw,
  output logic       clear,
  output logic       busy,
  output logic       frame_done,
  output logic       error,
  output logic [7:0] frame_cnt
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLR_CMD  = 4'd1;
  localparam logic [3:0] S_CLR_WAIT = 4'd2;
  localparam logic [3:0] S_CAP_ARM  = 4'd3;
  localparam logic [3:0] S_CAP_CMD  = 4'd4;
  localparam logic [3:0] S_CAP_WAIT = 4'd5;
  localparam logic [3:0] S_RD_CMD   = 4'd6;
  localparam logic [3:0] S_RD_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ERR      = 4'd9;

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [15:0] r_cnt;
  logic        w_wait;
  logic        w_tmo;

  assign w_wait = (r_state == S_CLR_WAIT) ||
                  (r_state == S_CAP_WAIT) ||
                  (r_state == S_RD_WAIT);

  // a done arriving on the last counted cycle still wins
  assign w_tmo = !RWM_done && (r_cnt == TIMEOUT - 16'd1);

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (start)
            w_next = CLEAR_EN ? S_CLR_CMD : S_CAP_ARM;
        S_CLR_CMD:  w_next = S_CLR_WAIT;
        S_CLR_WAIT:
          if (RWM_done)   w_next = S_CAP_ARM;
          else if (w_tmo) w_next = S_ERR;
        S_CAP_ARM:
          if (cam_frame_valid) w_next = S_CAP_CMD;
        S_CAP_CMD:  w_next = S_CAP_WAIT;
        S_CAP_WAIT:
          if (RWM_done)   w_next = S_RD_CMD;
          else if (w_tmo) w_next = S_ERR;
        S_RD_CMD:   w_next = S_RD_WAIT;
        S_RD_WAIT:
          if (RWM_done)   w_next = S_DONE;
          else if (w_tmo) w_next = S_ERR;
        S_DONE:     w_next = S_IDLE;
        S_ERR:      w_next = S_ERR;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!w_wait)
      r_cnt <= '0;
    else if (!RWM_done)
      r_cnt <= r_cnt + 16'd1;
  end

  // outputs decode the next state so they line up with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      RWM_enable <= 1'b0;
      rw         <= 1'b0;
      clear      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      r_state    <= w_next;
      RWM_enable <= (w_next == S_CLR_CMD) ||
                    (w_next == S_CAP_CMD) ||
                    (w_next == S_RD_CMD);
      rw         <= (w_next == S_CAP_CMD) ||
                    (w_next == S_CAP_WAIT);
      clear      <= (w_next == S_CLR_CMD) ||
                    (w_next == S_CLR_WAIT);
      busy       <= (w_next != S_IDLE);
      frame_done <= (w_next == S_DONE);
      if (w_next == S_DONE)
        frame_cnt <= frame_cnt + 8'd1;
      if (abort)
        error <= 1'b0;
      else if (w_next == S_ERR)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rwm_frame_ctrl.sv
// tb_rwm_frame_ctrl: randomized frame sequences against a behavioural
// RWM responder and an expected strobe-order / frame-count model.
`timescale 1ns/1ps
module tb_rwm_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic       abort = 1'b0;
  logic       cam = 1'b0;
  logic       done_m = 1'b0;
  logic       done_man = 1'b0;
  logic       w_done;

  logic       en, rw, clr, busy, fd, err;
  logic [7:0] cnt;
  logic       en0, rw0, clr0, busy0, fd0, err0;
  logic [7:0] cnt0;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int lat_fixed = 0;
  bit model_on = 1'b1;
  int dcnt = 0;
  int viol = 0;
  int fd_cnt = 0;
  bit prev_en = 1'b0;
  bit prev_en0 = 1'b0;
  logic [1:0] sq[$];
  logic [1:0] sq0[$];

  assign w_done = done_m | done_man;

  always #5 clk = ~clk;

  rwm_frame_ctrl #(.TIMEOUT(16'd100), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cam_frame_valid(cam), .RWM_done(w_done),
    .RWM_enable(en), .rw(rw), .clear(clr), .busy(busy),
    .frame_done(fd), .error(err), .frame_cnt(cnt)
  );

  rwm_frame_ctrl #(.TIMEOUT(16'd100), .CLEAR_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .cam_frame_valid(cam), .RWM_done(w_done),
    .RWM_enable(en0), .rw(rw0), .clear(clr0), .busy(busy0),
    .frame_done(fd0), .error(err0), .frame_cnt(cnt0)
  );

  // RWM responder: done is seen by the DUT L clock edges after a strobe
  initial forever begin
    @(negedge clk);
    done_m = 1'b0;
    if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) done_m = 1'b1;
    end else if (model_on && (en || en0)) begin
      dcnt = (lat_fixed != 0) ? lat_fixed - 1
                              : $urandom_range(20, 2) - 1;
    end
  end

  always @(negedge clk) begin
    if (en && (prev_en || !busy)) viol <= viol + 1;
    if (en0 && (prev_en0 || !busy0)) viol <= viol + 1;
    if (en) sq.push_back({rw, clr});
    if (en0) sq0.push_back({rw0, clr0});
    if (fd) fd_cnt <= fd_cnt + 1;
    prev_en <= en;
    prev_en0 <= en0;
  end

  task automatic run_frame(input int tag);
    int cd;
    bit got;
    int sig;
    sq.delete();
    cd = $urandom_range(15, 0);
    cam = 1'b0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (n == cd) cam = 1'b1;
      if (fd) got = 1'b1;
      start = got ? 1'b0 : ($urandom_range(3, 0) == 0);
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL frame%0d_timeout got=no_frame_done exp=frame_done", tag);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    checks++;
    if (cnt !== exp_cnt[7:0]) begin
      failures++;
      $display("FAIL frame%0d_cnt got=%0d exp=%0d", tag, cnt, exp_cnt);
    end
    sig = 0;
    foreach (sq[i]) sig = (sig << 2) | int'(sq[i]);
    checks++;
    if (sq.size() != 3 || sig != 'b01_10_00) begin
      failures++;
      $display("FAIL frame%0d_strobes got=%0d/%0h exp=3/%0h",
               tag, sq.size(), sig, 'b01_10_00);
    end
    @(negedge clk);
    checks++;
    if ({busy, fd} !== 2'b00) begin
      failures++;
      $display("FAIL frame%0d_end got=%b exp=00", tag, {busy, fd});
    end
    cam = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({en, rw, clr, busy, fd, err, cnt} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outs got=%0h exp=0",
               {en, rw, clr, busy, fd, err, cnt});
    end
    checks++;
    if ({en0, rw0, clr0, busy0, fd0, err0, cnt0} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outs0 got=%0h exp=0",
               {en0, rw0, clr0, busy0, fd0, err0, cnt0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    lat_fixed = 10;
    run_frame(0);
    lat_fixed = 0;
    run_frame(1);
  endtask

  task automatic test_no_clear();
    bit got;
    int sig;
    sq0.delete();
    cam = 1'b1;
    got = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (fd0) got = 1'b1;
    end
    sig = 0;
    foreach (sq0[i]) sig = (sig << 2) | int'(sq0[i]);
    checks++;
    if (!got || sq0.size() != 2 || sig != 'b10_00) begin
      failures++;
      $display("FAIL noclr_strobes got=%0d/%0d/%0h exp=1/2/%0h",
               got, sq0.size(), sig, 'b10_00);
    end
    checks++;
    if (cnt0 !== 8'd1) begin
      failures++;
      $display("FAIL noclr_cnt got=%0d exp=1", cnt0);
    end
    cam = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got;
    model_on = 1'b0;
    lat_fixed = 10;
    got = 1'b0;
    cam = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // clear still needs a done; answer it manually
    for (int n = 0; n < 200 && !got; n++) begin
      if (en && clr) begin
        repeat (4) @(negedge clk);
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
      end
      if (en && rw) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL tmo_write_strobe got=none exp=strobe");
    end
    repeat (100) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b01) begin
      failures++;
      $display("FAIL tmo_early got=%b exp=01", {err, busy});
    end
    @(negedge clk);
    checks++;
    if ({err, busy, rw, en} !== 4'b1100) begin
      failures++;
      $display("FAIL tmo_err got=%b exp=1100", {err, busy, rw, en});
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b11) begin
      failures++;
      $display("FAIL tmo_sticky got=%b exp=11", {err, busy});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({err, busy, cnt} !== {2'b00, exp_cnt[7:0]}) begin
      failures++;
      $display("FAIL tmo_abort got=%b/%0d exp=00/%0d",
               {err, busy}, cnt, exp_cnt);
    end
    cam = 1'b0;
    model_on = 1'b1;
    lat_fixed = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_boundary();
    bit got;
    lat_fixed = 101;
    run_frame(2);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL bound_last_cycle_err got=%b exp=0", err);
    end
    lat_fixed = 102;
    sq.delete();
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (err) got = 1'b1;
    end
    checks++;
    if (!got || sq.size() != 1) begin
      failures++;
      $display("FAIL bound_late_err got=%0d/%0d exp=1/1", got, sq.size());
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lat_fixed = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_done();
    bit got;
    int fd0c;
    lat_fixed = 10;
    cam = 1'b1;
    got = 1'b0;
    fd0c = fd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      if (en && !rw && !clr) got = 1'b1;
      else @(negedge clk);
    end
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!got || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_rd got=%0d/%b exp=1/0", got, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (fd_cnt != fd0c || cnt !== exp_cnt[7:0]) begin
      failures++;
      $display("FAIL abort_nodone got=%0d/%0d exp=%0d/%0d",
               fd_cnt, cnt, fd0c, exp_cnt);
    end
    cam = 1'b0;
    lat_fixed = 0;
  endtask

  task automatic test_reset_mid();
    bit got;
    int fd0c;
    lat_fixed = 10;
    cam = 1'b1;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      if (en && rw) got = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!got || {en, rw, clr, busy, fd, err, cnt} !== 14'd0) begin
      failures++;
      $display("FAIL reset_mid got=%0d/%0h exp=1/0",
               got, {en, rw, clr, busy, fd, err, cnt});
    end
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fd0c = fd_cnt;
    repeat (25) @(negedge clk);
    checks++;
    if (fd_cnt != fd0c || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_noresume got=%0d/%b exp=%0d/0",
               fd_cnt, busy, fd0c);
    end
    lat_fixed = 0;
    run_frame(3);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = exp_cnt;
    for (int f = 0; f < 256; f++) run_frame(100 + f);
    checks++;
    if (cnt !== c0[7:0]) begin
      failures++;
      $display("FAIL b2b_wrap got=%0d exp=%0d", cnt, c0);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL strobe_rules got=%0d exp=0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_clear();
    test_timeout();
    test_boundary();
    test_abort_done();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
